lsu_ctrl: RTL and testbench

- Load/store unit placed between the core's execute stage and the data memory port.
- Accepts one load/store at a time over a valid/ready handshake and checks alignment.
- Converts the access into a word-aligned memory transaction with a byte write mask.
- For loads, extracts the addressed byte/half/word and sign- or zero-extends it; returns the result, or an error, over a response handshake.

---
 rtl/lsu_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: one access at a time from execute stage to a word-wide
// data memory port, with alignment checks, store lane formation, load
// extraction/extension and a bounded wait for the memory response.
module lsu_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    // core request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    // core response
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    // data memory port
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                wen_q, wen_d;
    logic [2:0]          func3_q, func3_d;
    logic [1:0]          off_q, off_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wmask_q, mem_wmask_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic                req_bad;
    logic [3:0]          st_wmask;
    logic [DATA_W-1:0]   st_wdata;
    logic [DATA_W-1:0]   ld_shift;
    logic [DATA_W-1:0]   ld_data;

    // Request decode: legality/alignment and store lane placement
    always_comb begin
        req_bad  = 1'b0;
        st_wmask = 4'b0000;
        st_wdata = '0;
        if (req_wen) begin
            req_bad = (req_func3 >= 3'd3);
        end else begin
            req_bad = (req_func3 == 3'd3) || (req_func3 == 3'd6) || (req_func3 == 3'd7);
        end
        if ((req_func3[1:0] == 2'd1) && req_addr[0]) begin
            req_bad = 1'b1;
        end
        if ((req_func3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
        case (req_func3[1:0])
            2'd0: begin
                st_wmask = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                st_wmask = 4'b0011 << req_addr[1:0];
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_wmask = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    // Load extraction: shift addressed byte/half down, then extend
    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        ld_data  = '0;
        case (func3_q)
            3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_data = {24'd0, ld_shift[7:0]};
            3'd5:    ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
        if (wen_q) begin
            ld_data = '0;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        func3_d      = func3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    func3_d = req_func3;
                    off_d   = req_addr[1:0];
                    if (req_bad) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = S_REQ;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_wen;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = req_wen ? st_wdata : '0;
                        mem_wmask_d = req_wen ? st_wmask : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d     = S_WAIT;
                    mem_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            S_WAIT: begin
                // a response arriving on the last allowed cycle still counts
                if (mem_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = ld_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wen_q        <= 1'b0;
            func3_q      <= 3'd0;
            off_q        <= 2'd0;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            func3_q      <= func3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected memory requests and
// responses from a byte-lane reference model; memory and response monitors
// pop and compare independently.
module tb_lsu_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_wen;
    logic [2:0]    req_func3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_valid, mem_ready, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          mem_rvalid, mem_rvalid_m, stray_rvalid;

    assign mem_rvalid = mem_rvalid_m | stray_rvalid;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          stall;
        int          k;      // WAIT cycles before mem_rvalid, -1 = never
        logic [31:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      cyc;
        int          rstall;
    } resp_exp_t;

    mem_exp_t  mq[$];
    resp_exp_t rq[$];
    int        n_chk  = 0;
    int        n_pass = 0;
    longint    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: access viewed as `size` consecutive bytes at offset o
    function automatic void model(
        input  logic wen, input logic [2:0] f3, input logic [31:0] addr,
        input  logic [31:0] wdata, input logic [31:0] rdata, input int k, input int stall,
        output bit legal, output mem_exp_t m, output logic [31:0] rd,
        output logic err, output int lat);
        int size;
        int o;
        longint unsigned u;
        size  = 1 << f3[1:0];
        o     = int'(addr % 4);
        legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (legal && (int'(addr % 4) % size) != 0) legal = 0;
        m.addr  = addr & ~32'h3;
        m.we    = wen;
        m.wmask = 4'b0000;
        m.wdata = 32'h0;
        m.stall = stall;
        m.k     = k;
        m.rdata = rdata;
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= o && i < o + size) m.wmask[i] = 1'b1;
                m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
            end
        end
        rd = 32'h0;
        if (!legal) begin
            err = 1'b1; lat = 1;
        end else if (k < 0) begin
            err = 1'b1; lat = 2 + stall + int'(TO);
        end else begin
            err = 1'b0; lat = 3 + stall + k;
            if (!wen) begin
                u = longint'(rdata);
                u = (u >> (8*o)) % (64'd1 << (8*size));
                if (f3 < 3'd4 && size < 4 && u >= (64'd1 << (8*size - 1)))
                    u = u - (64'd1 << (8*size));
                rd = 32'(u);
            end
        end
    endfunction

    // Issue one request (called at a negedge); queues expectations first
    task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall, input int k,
                         input logic [31:0] rdata, input int rstall);
        bit          legal;
        mem_exp_t    m;
        resp_exp_t   r;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          w;
        model(wen, f3, addr, wdata, rdata, k, stall, legal, m, rd, err, lat);
        w = 0;
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        if (legal) mq.push_back(m);
        r.rdata = rd; r.err = err; r.cyc = cyc + lat; r.rstall = rstall;
        rq.push_back(r);
        req_valid = 1'b1; req_wen = wen; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (!legal) begin
            check("err_no_mem_valid", 32'(mem_valid), 32'd0);
            check("err_resp_1cyc", 32'(resp_valid), 32'd1);
        end
    endtask

    // Memory model: checks request fields, stalls, then acks/returns data
    initial begin
        mem_exp_t    m;
        logic [31:0] a0;
        mem_ready = 1'b0; mem_rvalid_m = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_valid) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_req", 32'(mem_valid), 32'd0);
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                end else begin
                    m = mq.pop_front();
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_wmask", 32'(mem_wmask), 32'(m.wmask));
                    if (m.we) check("mem_wdata", mem_wdata, m.wdata);
                    a0 = mem_addr;
                    for (int i = 0; i < m.stall; i++) begin
                        @(negedge clk);
                        check("mem_valid_hold", 32'(mem_valid), 32'd1);
                        check("mem_addr_hold", mem_addr, a0);
                    end
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    check("mem_valid_drop", 32'(mem_valid), 32'd0);
                    if (m.k >= 0) begin
                        repeat (m.k) @(negedge clk);
                        mem_rvalid_m = 1'b1;
                        mem_rdata    = m.rdata;
                        @(negedge clk);
                        mem_rvalid_m = 1'b0;
                        mem_rdata    = $urandom;
                    end
                end
            end
        end
    end

    // Response monitor: compares value, error and arrival cycle; back-pressures
    initial begin
        resp_exp_t e;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                end else begin
                    e = rq.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    for (int i = 0; i < e.rstall; i++) begin
                        @(negedge clk);
                        check("resp_valid_hold", 32'(resp_valid), 32'd1);
                        check("resp_rdata_hold", resp_rdata, e.rdata);
                        check("req_ready_in_resp", 32'(req_ready), 32'd0);
                    end
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                    check("resp_valid_drop", 32'(resp_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    // Stimulus: reset, directed cases, random traffic, reset-in-WAIT
    initial begin
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          w;
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; stray_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        issue(1'b0, 3'd0, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_1234, 0);   // LB
        issue(1'b0, 3'd5, 32'h8000_0002, 32'h0, 1, 1, 32'hBEEF_0000, 0);   // LHU
        issue(1'b1, 3'd0, 32'h1000_0001, 32'h0000_00AB, 0, 0, 32'h0, 1);   // SB
        issue(1'b1, 3'd1, 32'h1000_0002, 32'h0000_1234, 0, 2, 32'h0, 0);   // SH
        issue(1'b0, 3'd2, 32'h0000_1002, 32'h0, 0, 0, 32'h0, 0);           // LW misaligned
        issue(1'b0, 3'd3, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 0);           // illegal load
        issue(1'b1, 3'd4, 32'h0000_1000, 32'h5, 0, 0, 32'h0, 0);           // illegal store
        issue(1'b0, 3'd2, 32'h0000_2000, 32'h0, 5, 0, 32'hCAFE_F00D, 3);   // both stalls
        issue(1'b0, 3'd1, 32'h0000_3002, 32'h0, 0, -1, 32'h0, 0);          // timeout
        issue(1'b0, 3'd4, 32'h0000_3003, 32'h0, 0, int'(TO) - 1, 32'h9A00_0000, 0);

        for (int t = 0; t < 60; t++) begin
            wen = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wen) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 >= 3'd3) f3 = f3 + 3'd1;
            end
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(wen, f3, addr, $urandom, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
                  $urandom, int'($urandom_range(0, 3)));
        end

        w = 0;
        while ((rq.size() != 0 || !req_ready) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_resp_queue", 32'(rq.size()), 32'd0);

        // Store abandoned by reset while waiting for its ack
        begin
            mem_exp_t m;
            m.addr = 32'h0000_0200; m.we = 1'b1; m.wmask = 4'b1111; m.wdata = 32'h1357_9BDF;
            m.stall = 0; m.k = -1; m.rdata = 32'h0;
            mq.push_back(m);
        end
        req_valid = 1'b1; req_wen = 1'b1; req_func3 = 3'd2;
        req_addr = 32'h0000_0200; req_wdata = 32'h1357_9BDF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_valid", 32'(mem_valid), 32'd0);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_mem_wdata", mem_wdata, 32'h0);
        check("arst_mem_wmask", 32'(mem_wmask), 32'd0);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_resp_rdata", resp_rdata, 32'h0);
        check("arst_resp_err", 32'(resp_err), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stray_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        stray_rvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("stray_no_resp", 32'(resp_valid), 32'd0);
            check("stray_req_ready", 32'(req_ready), 32'd1);
        end
        check("mem_queue_empty", 32'(mq.size()), 32'd0);
        check("resp_queue_empty", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
